// File: rtl/alu_pipe.sv
// ---------------------------------------------------------------------------
// alu_pipe
//
// Two-stage pipelined ALU with a valid/ready handshake on both sides, a 4-bit
// opcode space (logic, shifts, compare, saturating arithmetic), status flags
// and an internal accumulator for chained operations.
//
// Stage 1 captures the request. Stage 2 computes the result from the stage-1
// registers and holds it until the consumer accepts it. The accumulator lives
// entirely in stage 2, so back-to-back accumulator operations chain without
// any forwarding or hazard logic.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_valid   request valid
//   in_ready   request accepted when in_valid && in_ready
//   in_op      4-bit opcode
//   in_acc     use the accumulator as A and write the result back to it
//   in_a/in_b  WIDTH-bit operands
//   out_valid  result valid
//   out_ready  consumer accepts when out_valid && out_ready
//   out_y      WIDTH-bit result
//   out_flags  {ovf, carry, neg, zero}
// ---------------------------------------------------------------------------
module alu_pipe #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic             in_acc,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic [3:0]       out_flags
);

  typedef enum logic [3:0] {
    OP_PASSA  = 4'd0,
    OP_ADD    = 4'd1,
    OP_SUB    = 4'd2,
    OP_AND    = 4'd3,
    OP_OR     = 4'd4,
    OP_INC    = 4'd5,
    OP_DEC    = 4'd6,
    OP_PASSB  = 4'd7,
    OP_XOR    = 4'd8,
    OP_SHL    = 4'd9,
    OP_SHR    = 4'd10,
    OP_SRA    = 4'd11,
    OP_SLT    = 4'd12,
    OP_ADDS   = 4'd13,
    OP_SUBS   = 4'd14,
    OP_CLRACC = 4'd15
  } op_e;

  localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  // Stage-1 request registers
  logic             r_s1Valid;
  op_e              r_s1Op;
  logic             r_s1Acc;
  logic [WIDTH-1:0] r_s1A;
  logic [WIDTH-1:0] r_s1B;

  // Stage-2 output registers and accumulator
  logic             r_outValid;
  logic [WIDTH-1:0] r_outY;
  logic [3:0]       r_outFlags;
  logic [WIDTH-1:0] r_acc;

  // Handshake enables and datapath wires
  logic             w_s2En;
  logic             w_s1En;
  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic [SHW-1:0]   w_sh;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH:0]   w_inc;
  logic [WIDTH-1:0] w_dec;
  logic             w_addOvf;
  logic             w_subOvf;
  logic [WIDTH-1:0] w_y;
  logic             w_carry;
  logic             w_ovf;
  logic [3:0]       w_flags;

  // Stage 2 can take a new entry when its slot is empty or being drained this
  // cycle; stage 1 can take a new request when it is empty or moving forward.
  assign w_s2En   = !r_outValid || out_ready;
  assign w_s1En   = !r_s1Valid || w_s2En;
  assign in_ready = w_s1En;

  assign out_valid = r_outValid;
  assign out_y     = r_outY;
  assign out_flags = r_outFlags;

  // Operand selection and shared arithmetic. The extra top bit of w_diff is
  // the unsigned borrow, since it only sets when A < B.
  assign w_a    = r_s1Acc ? r_acc : r_s1A;
  assign w_b    = r_s1B;
  assign w_sh   = r_s1B[SHW-1:0];
  assign w_sum  = {1'b0, w_a} + {1'b0, w_b};
  assign w_diff = {1'b0, w_a} - {1'b0, w_b};
  assign w_inc  = {1'b0, w_a} + {{WIDTH{1'b0}}, 1'b1};
  assign w_dec  = w_a - {{(WIDTH-1){1'b0}}, 1'b1};

  assign w_addOvf = (w_a[WIDTH-1] == w_b[WIDTH-1]) && (w_sum[WIDTH-1]  != w_a[WIDTH-1]);
  assign w_subOvf = (w_a[WIDTH-1] != w_b[WIDTH-1]) && (w_diff[WIDTH-1] != w_a[WIDTH-1]);

  // Result and carry/overflow selection for the stage-2 operation. Saturating
  // ops clamp towards the sign of A, which is the direction of overflow.
  always_comb begin
    w_y     = '0;
    w_carry = 1'b0;
    w_ovf   = 1'b0;
    case (r_s1Op)
      OP_PASSA: w_y = w_a;
      OP_ADD: begin
        w_y     = w_sum[WIDTH-1:0];
        w_carry = w_sum[WIDTH];
        w_ovf   = w_addOvf;
      end
      OP_SUB: begin
        w_y     = w_diff[WIDTH-1:0];
        w_carry = w_diff[WIDTH];
        w_ovf   = w_subOvf;
      end
      OP_AND:   w_y = w_a & w_b;
      OP_OR:    w_y = w_a | w_b;
      OP_INC: begin
        w_y     = w_inc[WIDTH-1:0];
        w_carry = w_inc[WIDTH];
        w_ovf   = (w_a == MAX_POS);
      end
      OP_DEC: begin
        w_y     = w_dec;
        w_carry = (w_a == '0);
        w_ovf   = (w_a == MIN_NEG);
      end
      OP_PASSB: w_y = w_b;
      OP_XOR:   w_y = w_a ^ w_b;
      OP_SHL:   w_y = w_a << w_sh;
      OP_SHR:   w_y = w_a >> w_sh;
      OP_SRA:   w_y = $signed(w_a) >>> w_sh;
      OP_SLT:   w_y = {{(WIDTH-1){1'b0}}, ($signed(w_a) < $signed(w_b))};
      OP_ADDS: begin
        w_y     = w_addOvf ? (w_a[WIDTH-1] ? MIN_NEG : MAX_POS) : w_sum[WIDTH-1:0];
        w_carry = w_sum[WIDTH];
        w_ovf   = w_addOvf;
      end
      OP_SUBS: begin
        w_y     = w_subOvf ? (w_a[WIDTH-1] ? MIN_NEG : MAX_POS) : w_diff[WIDTH-1:0];
        w_carry = w_diff[WIDTH];
        w_ovf   = w_subOvf;
      end
      OP_CLRACC: w_y = '0;
      default:   w_y = '0;
    endcase
  end

  assign w_flags = {w_ovf, w_carry, w_y[WIDTH-1], (w_y == '0)};

  // Stage 1: capture the request whenever the slot can advance. Data only
  // loads with a valid request so idle cycles leave the operands untouched.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1Valid <= 1'b0;
      r_s1Op    <= OP_PASSA;
      r_s1Acc   <= 1'b0;
      r_s1A     <= '0;
      r_s1B     <= '0;
    end else if (w_s1En) begin
      r_s1Valid <= in_valid;
      if (in_valid) begin
        r_s1Op  <= op_e'(in_op);
        r_s1Acc <= in_acc;
        r_s1A   <= in_a;
        r_s1B   <= in_b;
      end
    end
  end

  // Stage 2: load the computed result and update the accumulator. Nothing
  // here moves while the consumer stalls a valid result, so out_y, out_flags
  // and the accumulator are stable under backpressure. CLRACC yields zero, so
  // writing w_y clears the accumulator for it as well.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_outValid <= 1'b0;
      r_outY     <= '0;
      r_outFlags <= '0;
      r_acc      <= '0;
    end else if (w_s2En) begin
      r_outValid <= r_s1Valid;
      if (r_s1Valid) begin
        r_outY     <= w_y;
        r_outFlags <= w_flags;
        if (r_s1Acc || (r_s1Op == OP_CLRACC)) begin
          r_acc <= w_y;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// ---------------------------------------------------------------------------
// tb_alu_pipe
//
// Directed testbench for alu_pipe. Two instances are exercised: a 32-bit one
// for arithmetic, chaining, backpressure and reset, and an 8-bit one for the
// shift/compare boundary cases. Expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_alu_pipe;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        inValid32, inReady32, inAcc32, outValid32, outReady32;
  logic [3:0]  inOp32, outFlags32;
  logic [31:0] inA32, inB32, outY32;

  logic        inValid8, inReady8, inAcc8, outValid8, outReady8;
  logic [3:0]  inOp8, outFlags8;
  logic [7:0]  inA8, inB8, outY8;

  int errCount   = 0;
  int checkCount = 0;

  // Backpressure stream tables and bookkeeping
  logic [3:0]  bpOp [6];
  logic [31:0] bpA  [6];
  logic [31:0] bpB  [6];
  logic [31:0] bpY  [6];
  logic [3:0]  bpF  [6];
  int          issued, rcv, occ;
  logic        accept, drain;

  always #5 clk = ~clk;

  alu_pipe #(.WIDTH(32)) u32 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (inValid32),
    .in_ready  (inReady32),
    .in_op     (inOp32),
    .in_acc    (inAcc32),
    .in_a      (inA32),
    .in_b      (inB32),
    .out_valid (outValid32),
    .out_ready (outReady32),
    .out_y     (outY32),
    .out_flags (outFlags32)
  );

  alu_pipe #(.WIDTH(8)) u8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (inValid8),
    .in_ready  (inReady8),
    .in_op     (inOp8),
    .in_acc    (inAcc8),
    .in_a      (inA8),
    .in_b      (inB8),
    .out_valid (outValid8),
    .out_ready (outReady8),
    .out_y     (outY8),
    .out_flags (outFlags8)
  );

  // Single comparison point: every check in the bench goes through here.
  task automatic checkEq(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) else begin
      errCount++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drive one request onto the selected instance.
  task automatic applyStimulus(input bit dut8, input logic [3:0] op, input logic acc,
                               input logic [31:0] a, input logic [31:0] b);
    if (dut8) begin
      inValid8 = 1'b1; inOp8 = op; inAcc8 = acc; inA8 = a[7:0]; inB8 = b[7:0];
    end else begin
      inValid32 = 1'b1; inOp32 = op; inAcc32 = acc; inA32 = a; inB32 = b;
    end
  endtask

  task automatic idle();
    inValid32 = 1'b0;
    inValid8  = 1'b0;
  endtask

  // Compare a presented result on the selected instance.
  task automatic checkOutput(input string tag, input bit dut8,
                             input logic [31:0] expY, input logic [3:0] expFlags);
    checkEq({tag, " valid"}, 32'(dut8 ? outValid8 : outValid32), 32'd1);
    checkEq({tag, " y"},     dut8 ? 32'(outY8) : outY32, expY);
    checkEq({tag, " flags"}, 32'(dut8 ? outFlags8 : outFlags32), 32'(expFlags));
  endtask

  // Issue one op into an idle pipeline at a falling edge, confirm the result
  // is absent after the accept edge and present after the following edge.
  task automatic runOne(input string tag, input bit dut8, input logic [3:0] op, input logic acc,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] expY, input logic [3:0] expFlags);
    applyStimulus(dut8, op, acc, a, b);
    #1;
    checkEq({tag, " in_ready"}, 32'(dut8 ? inReady8 : inReady32), 32'd1);
    @(posedge clk); @(negedge clk);
    idle();
    checkEq({tag, " latency"}, 32'(dut8 ? outValid8 : outValid32), 32'd0);
    @(posedge clk); @(negedge clk);
    checkOutput(tag, dut8, expY, expFlags);
  endtask

  initial begin
    bpOp[0] = 4'd1;  bpA[0] = 32'h10;       bpB[0] = 32'h20;       bpY[0] = 32'h30;       bpF[0] = 4'b0000;
    bpOp[1] = 4'd2;  bpA[1] = 32'h5;        bpB[1] = 32'h7;        bpY[1] = 32'hFFFF_FFFE; bpF[1] = 4'b0110;
    bpOp[2] = 4'd3;  bpA[2] = 32'hF0F0_F0F0; bpB[2] = 32'h0FF0_0FF0; bpY[2] = 32'h00F0_00F0; bpF[2] = 4'b0000;
    bpOp[3] = 4'd8;  bpA[3] = 32'hAAAA_AAAA; bpB[3] = 32'hAAAA_AAAA; bpY[3] = 32'h0;        bpF[3] = 4'b0001;
    bpOp[4] = 4'd9;  bpA[4] = 32'h1;        bpB[4] = 32'h4;        bpY[4] = 32'h10;       bpF[4] = 4'b0000;
    bpOp[5] = 4'd12; bpA[5] = 32'hFFFF_FFFF; bpB[5] = 32'h1;        bpY[5] = 32'h1;        bpF[5] = 4'b0000;

    rst_n = 1'b0;
    inValid32 = 1'b0; inOp32 = '0; inAcc32 = 1'b0; inA32 = '0; inB32 = '0; outReady32 = 1'b1;
    inValid8  = 1'b0; inOp8  = '0; inAcc8  = 1'b0; inA8  = '0; inB8  = '0; outReady8  = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkEq("reset out_valid", 32'(outValid32), 32'd0);
    checkEq("reset out_y",     outY32,          32'd0);
    checkEq("reset flags",     32'(outFlags32), 32'd0);
    checkEq("reset in_ready",  32'(inReady32),  32'd1);
    checkEq("reset8 in_ready", 32'(inReady8),   32'd1);

    // 32-bit arithmetic boundaries
    runOne("add wrap",  0, 4'd1,  1'b0, 32'hFFFF_FFFF, 32'h1,  32'h0,          4'b0101);
    runOne("adds sat",  0, 4'd13, 1'b0, 32'h7FFF_FFF0, 32'h20, 32'h7FFF_FFFF,  4'b1000);
    runOne("subs sat",  0, 4'd14, 1'b0, 32'h8000_0000, 32'h1,  32'h8000_0000,  4'b1010);

    // Accumulator chain: CLRACC then four INC back to back, no bubbles
    for (int k = 0; k <= 5; k++) begin
      if (k < 5) applyStimulus(0, (k == 0) ? 4'd15 : 4'd5, 1'b1, 32'h0, 32'h0);
      else       idle();
      #1;
      if (k < 5)  checkEq("chain in_ready", 32'(inReady32), 32'd1);
      if (k >= 2) checkOutput("chain", 0, 32'(k - 2), (k == 2) ? 4'b0001 : 4'b0000);
      @(posedge clk); @(negedge clk);
    end
    checkOutput("chain last", 0, 32'd4, 4'b0000);
    runOne("acc readback", 0, 4'd0, 1'b1, 32'h0, 32'h0, 32'd4, 4'b0000);

    // Backpressure stream with out_ready pattern 1,0,0 repeating
    @(negedge clk);
    issued = 0; rcv = 0; occ = 0;
    for (int cyc = 0; cyc < 60 && rcv < 6; cyc++) begin
      outReady32 = (cyc % 3 == 0);
      if (issued < 6) applyStimulus(0, bpOp[issued], 1'b0, bpA[issued], bpB[issued]);
      else            idle();
      #1;
      checkEq("bp in_ready", 32'(inReady32), 32'(!(occ == 2 && !outReady32)));
      if (outValid32) begin
        checkEq($sformatf("bp y%0d", rcv),     outY32,          bpY[rcv]);
        checkEq($sformatf("bp flags%0d", rcv), 32'(outFlags32), 32'(bpF[rcv]));
      end
      accept = inValid32 && inReady32;
      drain  = outValid32 && outReady32;
      if (drain)  rcv++;
      if (accept) issued++;
      occ = occ + (accept ? 1 : 0) - (drain ? 1 : 0);
      @(posedge clk); @(negedge clk);
    end
    idle();
    outReady32 = 1'b1;
    checkEq("bp all received", 32'(rcv), 32'd6);
    checkEq("bp no duplicate", 32'(outValid32), 32'd0);

    // 8-bit shift/compare and saturation boundaries
    runOne("sra8",  1, 4'd11, 1'b0, 32'h80, 32'h3,  32'hF0, 4'b0010);
    runOne("shr8",  1, 4'd10, 1'b0, 32'h80, 32'h3,  32'h10, 4'b0000);
    runOne("shl8",  1, 4'd9,  1'b0, 32'h80, 32'h9,  32'h00, 4'b0001);
    runOne("slt8",  1, 4'd12, 1'b0, 32'hFF, 32'h1,  32'h01, 4'b0000);
    runOne("adds8", 1, 4'd13, 1'b0, 32'h70, 32'h20, 32'h7F, 4'b1000);
    runOne("subs8", 1, 4'd14, 1'b0, 32'h80, 32'h1,  32'h80, 4'b1010);
    runOne("dec8",  1, 4'd6,  1'b0, 32'h00, 32'h0,  32'hFF, 4'b0110);

    // Reset with both stages full and accumulator at 5
    runOne("set acc", 0, 4'd7, 1'b1, 32'h0, 32'h5, 32'h5, 4'b0000);
    outReady32 = 1'b0;
    applyStimulus(0, 4'd1, 1'b0, 32'h1, 32'h1);
    #1;
    checkEq("fill in_ready", 32'(inReady32), 32'd1);
    @(posedge clk); @(negedge clk);
    idle();
    #1;
    checkEq("full in_ready",  32'(inReady32),  32'd0);
    checkEq("full out_valid", 32'(outValid32), 32'd1);
    checkEq("full out_y",     outY32,          32'h5);
    rst_n = 1'b0;
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkEq("rst out_valid", 32'(outValid32), 32'd0);
    checkEq("rst in_ready",  32'(inReady32),  32'd1);
    checkEq("rst out_y",     outY32,          32'd0);
    outReady32 = 1'b1;
    runOne("acc cleared", 0, 4'd0, 1'b1, 32'h1234, 32'h0, 32'h0, 4'b0001);

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
